// File: rtl/addr_filter_if.sv
// Bus bundle for addr_filter: table programming, filter controls, rx byte stream and result.
interface addr_filter_if;
    logic [47:0] sa;
    logic        tbl_we;
    logic [3:0]  tbl_idx;
    logic [2:0]  tbl_pos;
    logic [7:0]  tbl_data;
    logic        tbl_clr;
    logic        promisc;
    logic        allmulti;
    logic        rx_sof;
    logic        rx_vld;
    logic [7:0]  rx_data;
    logic        rx_abort;
    logic        match_vld;
    logic        match;
    logic [1:0]  match_src;

    modport master (
        output sa, tbl_we, tbl_idx, tbl_pos, tbl_data, tbl_clr, promisc, allmulti,
        output rx_sof, rx_vld, rx_data, rx_abort,
        input  match_vld, match, match_src
    );

    modport slave (
        input  sa, tbl_we, tbl_idx, tbl_pos, tbl_data, tbl_clr, promisc, allmulti,
        input  rx_sof, rx_vld, rx_data, rx_abort,
        output match_vld, match, match_src
    );
endinterface

// File: rtl/addr_filter.sv
// Destination-address filter: compares the first six rx bytes against the station address,
// a programmable table, broadcast and multicast rules, and reports one result per frame.
module addr_filter #(
    parameter int unsigned NADDR = 14
) (
    input logic         clk,
    input logic         rst,
    addr_filter_if.slave bus
);
    typedef enum logic [1:0] {StIdle, StCmp, StSkip} state_e;

    state_e           r_state;
    logic [47:0]      r_tbl [NADDR];
    logic [NADDR-1:0] r_valid;
    logic [NADDR-1:0] r_hit;
    logic [2:0]       r_cnt;
    logic             r_sta_hit;
    logic             r_bcast;
    logic             r_mcast;
    logic             r_match_vld;
    logic             r_match;
    logic [1:0]       r_match_src;

    logic             w_wr_ok;
    logic [NADDR-1:0] w_wr_mask;
    logic [NADDR-1:0] w_byte_hit;
    logic [7:0]       w_sa_byte;
    logic             w_sta_fin;
    logic             w_bc_fin;
    logic             w_mc_fin;

    function automatic logic [7:0] f_byte(input logic [47:0] v, input logic [2:0] p);
        case (p)
            3'd0:    return v[7:0];
            3'd1:    return v[15:8];
            3'd2:    return v[23:16];
            3'd3:    return v[31:24];
            3'd4:    return v[39:32];
            3'd5:    return v[47:40];
            default: return 8'h00;
        endcase
    endfunction

    assign w_wr_ok = bus.tbl_we && (32'(bus.tbl_idx) < NADDR) && (bus.tbl_pos <= 3'd5);

    always_comb begin
        w_wr_mask = '0;
        for (int i = 0; i < NADDR; i++) begin
            w_wr_mask[i] = w_wr_ok && (bus.tbl_idx == 4'(i));
        end
    end

    // An entry being rewritten mid-frame can no longer be trusted for this frame.
    always_comb begin
        w_byte_hit = '0;
        for (int i = 0; i < NADDR; i++) begin
            w_byte_hit[i] = r_hit[i] && !w_wr_mask[i] &&
                            (f_byte(r_tbl[i], r_cnt) == bus.rx_data);
        end
    end

    assign w_sa_byte = f_byte(bus.sa, r_cnt);
    assign w_sta_fin = r_sta_hit && (w_sa_byte == bus.rx_data);
    assign w_bc_fin  = r_bcast && (bus.rx_data == 8'hFF);
    assign w_mc_fin  = (r_cnt == 3'd0) ? bus.rx_data[0] : r_mcast;

    always_ff @(posedge clk) begin
        for (int i = 0; i < NADDR; i++) begin
            if (w_wr_mask[i]) begin
                case (bus.tbl_pos)
                    3'd0:    r_tbl[i][7:0]   <= bus.tbl_data;
                    3'd1:    r_tbl[i][15:8]  <= bus.tbl_data;
                    3'd2:    r_tbl[i][23:16] <= bus.tbl_data;
                    3'd3:    r_tbl[i][31:24] <= bus.tbl_data;
                    3'd4:    r_tbl[i][39:32] <= bus.tbl_data;
                    3'd5:    r_tbl[i][47:40] <= bus.tbl_data;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || bus.tbl_clr) begin
            r_valid <= '0;
        end else begin
            for (int i = 0; i < NADDR; i++) begin
                if (w_wr_mask[i]) r_valid[i] <= (bus.tbl_pos == 3'd5);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= StIdle;
            r_cnt       <= 3'd0;
            r_hit       <= '0;
            r_sta_hit   <= 1'b0;
            r_bcast     <= 1'b0;
            r_mcast     <= 1'b0;
            r_match_vld <= 1'b0;
            r_match     <= 1'b0;
            r_match_src <= 2'd0;
        end else begin
            r_match_vld <= 1'b0;
            if (bus.rx_sof) begin
                r_state   <= StCmp;
                r_cnt     <= 3'd0;
                r_hit     <= r_valid & ~w_wr_mask;
                r_sta_hit <= 1'b1;
                r_bcast   <= 1'b1;
                r_mcast   <= 1'b0;
            end else if (bus.rx_abort) begin
                r_state <= StIdle;
            end else if (r_state == StCmp) begin
                if (bus.rx_vld) begin
                    r_hit     <= w_byte_hit;
                    r_sta_hit <= w_sta_fin;
                    r_bcast   <= w_bc_fin;
                    r_mcast   <= w_mc_fin;
                    if (r_cnt == 3'd5) begin
                        r_state     <= StSkip;
                        r_match_vld <= 1'b1;
                        if (w_sta_fin) begin
                            r_match <= 1'b1; r_match_src <= 2'd0;
                        end else if (|w_byte_hit) begin
                            r_match <= 1'b1; r_match_src <= 2'd1;
                        end else if (w_bc_fin) begin
                            r_match <= 1'b1; r_match_src <= 2'd2;
                        end else if (bus.promisc || (bus.allmulti && w_mc_fin)) begin
                            r_match <= 1'b1; r_match_src <= 2'd3;
                        end else begin
                            r_match <= 1'b0; r_match_src <= 2'd0;
                        end
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end else begin
                    r_hit <= r_hit & ~w_wr_mask;
                end
            end
        end
    end

    assign bus.match_vld = r_match_vld;
    assign bus.match     = r_match;
    assign bus.match_src = r_match_src;
endmodule

// File: doc/addr_filter.md
ADDR_FILTER -- requirements
Module: addr_filter

Interface
REQ-001 The block SHALL have parameter NADDR, default 14, meaning number of writable filter entries (range 1..16).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port sa, input, 48, station address: byte0 is sa[7:0], byte5 is sa[47:40]; driven from the low 48 bits of the station-address ROM output.
REQ-005 The block SHALL have port tbl_we, input, 1, table byte write strobe.
REQ-006 The block SHALL have port tbl_idx, input, 4, entry index for the write.
REQ-007 The block SHALL have port tbl_pos, input, 3, byte position 0..5 for the write.
REQ-008 The block SHALL have port tbl_data, input, 8, write data.
REQ-009 The block SHALL have port tbl_clr, input, 1, clears all entry valid bits.
REQ-010 The block SHALL have port promisc, input, 1, accept all frames.
REQ-011 The block SHALL have port allmulti, input, 1, accept all multicast frames.
REQ-012 The block SHALL have port rx_sof, input, 1, pulse marking the start of a received frame.
REQ-013 The block SHALL have port rx_vld, input, 1, rx_data byte valid.
REQ-014 The block SHALL have port rx_data, input, 8, received byte, destination address first, byte0 first.
REQ-015 The block SHALL have port rx_abort, input, 1, terminates the current frame.
REQ-016 The block SHALL have port match_vld, output, 1, one-cycle result strobe.
REQ-017 The block SHALL have port match, output, 1, frame accepted; valid only with match_vld.
REQ-018 The block SHALL have port match_src, output, 2, reason: 0 station, 1 table, 2 broadcast, 3 promisc/allmulti.

Function
REQ-019 The table SHALL hold NADDR entries of 6 bytes plus one valid bit each.
REQ-020 tbl_we with tbl_idx<NADDR and tbl_pos<=5 SHALL write the byte; indices or positions out of range SHALL be ignored.
REQ-021 A write to tbl_pos=5 SHALL set that entry's valid bit; a write to pos 0..4 SHALL clear it.
REQ-022 tbl_clr SHALL clear all valid bits; if tbl_clr and tbl_we occur in the same cycle, tbl_clr SHALL win for valid bits while the data byte is still written.
REQ-023 The FSM SHALL have states IDLE, CMP, and SKIP.
REQ-024 IDLE: on rx_sof, the FSM SHALL go to CMP, set byte counter cnt=0, set the station-hit bit, and set the hit vector to the valid bits.
REQ-025 CMP: each rx_vld byte SHALL clear every hit bit whose byte[cnt] differs and clear the station-hit bit if sa byte[cnt] differs, record broadcast (all 0xFF) and multicast (byte0 bit0), then increment cnt.
REQ-026 The byte with cnt=5 SHALL produce match_vld high on the next cycle and move the FSM to SKIP.
REQ-027 The match priority SHALL be: station (src 0), else any table hit (1), else broadcast (2), else promisc, or allmulti on multicast (3); otherwise match=0 and match_src=0.
REQ-028 SKIP: bytes SHALL be ignored until rx_sof, which restarts CMP as in REQ-024.
REQ-029 rx_sof in CMP SHALL restart comparison with no result for the abandoned frame.
REQ-030 rx_abort in any state SHALL return the FSM to IDLE without match_vld; if rx_abort and rx_sof coincide, rx_sof SHALL win.
REQ-031 A table write to entry k while in CMP SHALL clear hit bit k for the current frame; sa is assumed static per frame.
REQ-032 rx_vld in IDLE SHALL be ignored; gaps in rx_vld SHALL only stall cnt.
REQ-033 match_vld SHALL never be asserted in two consecutive cycles.

Reset
REQ-034 rst SHALL set the FSM to IDLE, cnt=0, all valid bits to 0, and match_vld, match and match_src to 0; table data bytes are not reset.
REQ-035 rst asserted mid-frame SHALL drop that frame with no match_vld.

Verification
REQ-036 sa=0x0605_0403_0201 (byte0=01), frame dest 01 02 03 04 05 06 -> match_vld one cycle after the 6th byte, match=1, match_src=0.
REQ-037 Entry 3 written to AA BB CC DD EE 10 (pos 0..5), dest AA..10 -> match=1, src=1; then tbl_clr and the same frame -> match=0, src=0.
REQ-038 dest FF FF FF FF FF FF with an empty table -> match=1, src=2.
REQ-039 dest 01 00 5E 00 00 01 -> match=0 with allmulti=0; with allmulti=1 -> match=1, src=3.
REQ-040 rx_abort after byte 3, then rst mid-frame -> no match_vld; the following full station frame -> match=1.
REQ-041 Entry 2 rewritten at pos 0 during CMP of a frame matching entry 2 -> match=0.
